// File: rtl/amo_sequencer.sv
// amo_sequencer: runs one RV64A read-modify-write atomic at a time through the LSU port and the AMO ALU
module amo_sequencer #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [63:0]      req_addr_i,
  input  logic [63:0]      req_rs2_i,
  input  logic [4:0]       req_funct5_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic             mem_req_we_o,
  output logic [63:0]      mem_req_addr_o,
  output logic [63:0]      mem_req_wdata_o,
  input  logic             mem_resp_valid_i,
  input  logic             mem_resp_err_i,
  input  logic [63:0]      mem_resp_rdata_i,
  output logic             amo_valid_o,
  output logic [63:0]      amo_op_a_o,
  output logic [63:0]      amo_op_b_o,
  output logic [4:0]       amo_funct_o,
  input  logic             amo_ready_i,
  input  logic [63:0]      amo_result_i,
  output logic             cpl_valid_o,
  input  logic             cpl_ready_i,
  output logic [63:0]      cpl_rd_o,
  output logic [TAG_W-1:0] cpl_tag_o,
  output logic             cpl_fault_o,
  output logic             cpl_cause_o,
  output logic             busy_o
);
  typedef enum logic [3:0] {IDLE, RD_REQ, RD_WAIT, EXEC, EXEC_WAIT, WR_REQ, WR_WAIT, DONE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [63:0] addr_q, addr_d, rs2_q, rs2_d, old_q, old_d, res_q, res_d;
  logic [4:0] funct_q, funct_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic fault_q, fault_d, cause_q, cause_d, supp_q, supp_d;
  assign req_ready_o     = state_q == IDLE && !flush_i;
  assign mem_req_valid_o = state_q == RD_REQ || state_q == WR_REQ;
  assign mem_req_we_o    = state_q == WR_REQ;
  assign mem_req_addr_o  = addr_q;
  assign mem_req_wdata_o = res_q;
  assign amo_valid_o     = state_q == EXEC;
  assign amo_op_a_o      = old_q;
  assign amo_op_b_o      = rs2_q;
  assign amo_funct_o     = funct_q;
  assign cpl_valid_o     = state_q == DONE;
  assign cpl_rd_o        = old_q;
  assign cpl_tag_o       = tag_q;
  assign cpl_fault_o     = fault_q;
  assign cpl_cause_o     = cause_q;
  assign busy_o          = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rs2_d   = rs2_q;
    old_d   = old_q;
    res_d   = res_q;
    funct_d = funct_q;
    tag_d   = tag_q;
    fault_d = fault_q;
    cause_d = cause_q;
    supp_d  = supp_q;
    unique case (state_q)
      IDLE: if (req_valid_i && req_ready_o) begin
        addr_d  = req_addr_i;
        rs2_d   = req_rs2_i;
        funct_d = req_funct5_i;
        tag_d   = req_tag_i;
        old_d   = '0;
        res_d   = '0;
        supp_d  = 1'b0;
        cause_d = 1'b0;
        fault_d = |req_addr_i[2:0];
        state_d = |req_addr_i[2:0] ? DONE : RD_REQ;
      end
      RD_REQ: state_d = flush_i ? (mem_req_ready_i ? DRAIN : IDLE) : (mem_req_ready_i ? RD_WAIT : RD_REQ);
      RD_WAIT: if (mem_resp_valid_i) begin
        old_d   = mem_resp_err_i ? old_q : mem_resp_rdata_i;
        fault_d = mem_resp_err_i;
        cause_d = mem_resp_err_i;
        state_d = flush_i ? IDLE : (mem_resp_err_i ? DONE : EXEC);
      end else if (flush_i) state_d = DRAIN;
      EXEC: state_d = flush_i ? IDLE : EXEC_WAIT;
      EXEC_WAIT: if (flush_i) state_d = IDLE;
      else if (amo_ready_i) begin
        res_d   = amo_result_i;
        state_d = WR_REQ;
      end
      // a write that fires under flush is committed but must not complete
      WR_REQ: if (mem_req_ready_i) begin
        supp_d  = flush_i;
        state_d = WR_WAIT;
      end else if (flush_i) state_d = IDLE;
      WR_WAIT: begin
        supp_d = mem_resp_valid_i ? 1'b0 : (supp_q | flush_i);
        if (mem_resp_valid_i) begin
          fault_d = mem_resp_err_i;
          cause_d = mem_resp_err_i;
          state_d = (supp_q || flush_i) ? IDLE : DONE;
        end
      end
      DONE: state_d = (flush_i || cpl_ready_i) ? IDLE : DONE;
      DRAIN: state_d = mem_resp_valid_i ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rs2_q   <= '0;
      old_q   <= '0;
      res_q   <= '0;
      funct_q <= '0;
      tag_q   <= '0;
      fault_q <= 1'b0;
      cause_q <= 1'b0;
      supp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rs2_q   <= rs2_d;
      old_q   <= old_d;
      res_q   <= res_d;
      funct_q <= funct_d;
      tag_q   <= tag_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      supp_q  <= supp_d;
    end
  end
endmodule

// File: tb/tb_amo_sequencer.sv
// tb_amo_sequencer: scoreboard bench with memory, ALU and completion models around amo_sequencer
module tb_amo_sequencer;
  localparam int TAG_W = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid_i = 1'b0, req_ready_o, flush_i = 1'b0;
  logic [63:0] req_addr_i = '0, req_rs2_i = '0;
  logic [4:0] req_funct5_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [63:0] mem_req_addr_o, mem_req_wdata_o;
  logic mem_resp_valid_i, mem_resp_err_i;
  logic [63:0] mem_resp_rdata_i;
  logic amo_valid_o, amo_ready_i;
  logic [63:0] amo_op_a_o, amo_op_b_o, amo_result_i;
  logic [4:0] amo_funct_o;
  logic cpl_valid_o, cpl_ready_i, cpl_fault_o, cpl_cause_o, busy_o;
  logic [63:0] cpl_rd_o;
  logic [TAG_W-1:0] cpl_tag_o;

  always #5 clk = ~clk;

  amo_sequencer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_rs2_i(req_rs2_i), .req_funct5_i(req_funct5_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_err_i(mem_resp_err_i), .mem_resp_rdata_i(mem_resp_rdata_i),
    .amo_valid_o(amo_valid_o), .amo_op_a_o(amo_op_a_o), .amo_op_b_o(amo_op_b_o), .amo_funct_o(amo_funct_o),
    .amo_ready_i(amo_ready_i), .amo_result_i(amo_result_i),
    .cpl_valid_o(cpl_valid_o), .cpl_ready_i(cpl_ready_i), .cpl_rd_o(cpl_rd_o), .cpl_tag_o(cpl_tag_o),
    .cpl_fault_o(cpl_fault_o), .cpl_cause_o(cpl_cause_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [63:0] rd;
    logic fault, cause, chk_rd;
  } cpl_t;
  typedef struct packed {
    logic [63:0] addr, data;
  } wr_t;
  cpl_t exp_cpl[$];
  wr_t exp_wr[$];
  logic [63:0] exp_rd[$];
  logic [63:0] mem [logic [63:0]];
  int checks = 0, failures = 0;
  int mem_mode = 0, cpl_mode = 0, lat = 1;
  logic rd_err = 1'b0, wr_err = 1'b0;
  logic [4:0] fl [9] = '{5'h00, 5'h01, 5'h04, 5'h08, 5'h0c, 5'h10, 5'h14, 5'h18, 5'h1c};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [63:0] memrd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : {a[31:0], ~a[31:0]};
  endfunction

  // RV64A semantics of the read-modify-write value
  function automatic logic [63:0] amo(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b);
    case (f)
      5'h00: return a + b;
      5'h01: return b;
      5'h04: return a ^ b;
      5'h08: return a | b;
      5'h0c: return a & b;
      5'h10: return ($signed(a) < $signed(b)) ? a : b;
      5'h14: return ($signed(a) > $signed(b)) ? a : b;
      5'h18: return (a < b) ? a : b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  initial begin : mem_model
    logic p_on, p_we, p_err, s_on, s_we;
    logic [63:0] p_addr, s_addr, s_wdata;
    int p_cnt, stall;
    wr_t w;
    logic [63:0] ra;
    p_on = 1'b0; p_we = 1'b0; p_err = 1'b0; s_on = 1'b0; s_we = 1'b0;
    p_addr = '0; s_addr = '0; s_wdata = '0; p_cnt = 0; stall = 0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0; mem_resp_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (s_on) begin
        chk("mem_hold_valid", 64'(mem_req_valid_o), 64'd1);
        chk("mem_hold_addr", mem_req_addr_o, s_addr);
        chk("mem_hold_we", 64'(mem_req_we_o), 64'(s_we));
        if (s_we) chk("mem_hold_wdata", mem_req_wdata_o, s_wdata);
      end
      s_on = mem_req_valid_o && !mem_req_ready_i;
      s_addr = mem_req_addr_o; s_we = mem_req_we_o; s_wdata = mem_req_wdata_o;
      if (mem_req_valid_o && mem_req_ready_i) begin
        p_on = 1'b1; p_we = mem_req_we_o; p_addr = mem_req_addr_o; p_cnt = lat;
        p_err = mem_req_we_o ? wr_err : rd_err;
        if (mem_req_we_o) begin
          if (exp_wr.size() == 0) fail("unexpected_write");
          else begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_req_addr_o, w.addr);
            chk("wr_data", mem_req_wdata_o, w.data);
          end
          if (!wr_err) mem[mem_req_addr_o] = mem_req_wdata_o;
        end else begin
          if (exp_rd.size() == 0) fail("unexpected_read");
          else begin
            ra = exp_rd.pop_front();
            chk("rd_addr", mem_req_addr_o, ra);
          end
        end
      end
      stall = (mem_req_valid_o && !mem_req_ready_i) ? stall + 1 : 0;
      @(posedge clk); #1;
      mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0; mem_resp_rdata_i = '0;
      if (p_on) begin
        p_cnt--;
        if (p_cnt == 0) begin
          p_on = 1'b0;
          mem_resp_valid_i = 1'b1;
          mem_resp_err_i = p_err;
          mem_resp_rdata_i = p_we ? 64'h0 : memrd(p_addr);
        end
      end
      mem_req_ready_i = (mem_mode == 0) ? 1'b1 : (mem_mode == 2) ? (stall >= 3) : ($urandom_range(0, 2) == 0);
    end
  end

  initial begin : alu_model
    logic v, pv;
    logic [63:0] a, b;
    logic [4:0] f;
    pv = 1'b0;
    amo_ready_i = 1'b0; amo_result_i = '0;
    forever begin
      @(negedge clk);
      if (pv) chk("amo_valid_pulse", 64'(amo_valid_o), 64'd0);
      v = amo_valid_o; pv = v; a = amo_op_a_o; b = amo_op_b_o; f = amo_funct_o;
      @(posedge clk); #1;
      amo_ready_i = v;
      amo_result_i = v ? amo(f, a, b) : 64'h0;
    end
  end

  initial begin : cpl_monitor
    logic h_on, h_f, h_c;
    logic [63:0] h_rd;
    logic [TAG_W-1:0] h_tag;
    int hold;
    cpl_t e;
    h_on = 1'b0; h_f = 1'b0; h_c = 1'b0; h_rd = '0; h_tag = '0; hold = 0;
    cpl_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (h_on) begin
        chk("cpl_hold_valid", 64'(cpl_valid_o), 64'd1);
        chk("cpl_hold_rd", cpl_rd_o, h_rd);
        chk("cpl_hold_tag", 64'(cpl_tag_o), 64'(h_tag));
        chk("cpl_hold_fault", 64'({cpl_fault_o, cpl_cause_o}), 64'({h_f, h_c}));
        chk("cpl_hold_req_ready", 64'(req_ready_o), 64'd0);
      end
      h_on = cpl_valid_o && !cpl_ready_i;
      h_rd = cpl_rd_o; h_tag = cpl_tag_o; h_f = cpl_fault_o; h_c = cpl_cause_o;
      if (cpl_valid_o && cpl_ready_i) begin
        if (exp_cpl.size() == 0) fail("unexpected_cpl");
        else begin
          e = exp_cpl.pop_front();
          chk("cpl_tag", 64'(cpl_tag_o), 64'(e.tag));
          chk("cpl_fault", 64'(cpl_fault_o), 64'(e.fault));
          if (e.fault) chk("cpl_cause", 64'(cpl_cause_o), 64'(e.cause));
          if (e.chk_rd) chk("cpl_rd", cpl_rd_o, e.rd);
        end
      end
      hold = h_on ? hold + 1 : 0;
      @(posedge clk); #1;
      cpl_ready_i = (cpl_mode == 0) ? 1'b1 : (cpl_mode == 2) ? (hold >= 4) : 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] r, input logic [4:0] f, input logic [TAG_W-1:0] t);
    int n;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_addr_i = a; req_rs2_i = r; req_funct5_i = f; req_tag_i = t;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready_o && n < 200);
    if (!req_ready_o) fail("req_accept_timeout");
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic run_txn(input logic [63:0] a, input logic [63:0] r, input logic [4:0] f,
                         input logic [TAG_W-1:0] t, input logic rde, input logic wre, input int exp_lat);
    logic [63:0] old;
    logic mis;
    int n;
    old = memrd(a);
    mis = a[2:0] != 3'd0;
    rd_err = rde; wr_err = wre;
    if (!mis) exp_rd.push_back(a);
    if (!mis && !rde) exp_wr.push_back('{addr: a, data: amo(f, old, r)});
    exp_cpl.push_back('{tag: t, rd: old, fault: mis || rde || wre, cause: !mis, chk_rd: !mis && !rde});
    send(a, r, f, t);
    n = 0;
    do begin @(negedge clk); n++; end while (!cpl_valid_o && n < 300);
    if (exp_lat > 0) chk("cpl_latency", 64'(n), 64'(exp_lat));
    n = 0;
    while (exp_cpl.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_cpl.size() != 0) begin
      fail("cpl_timeout");
      exp_cpl.delete();
    end
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] a, r;
    logic rde, wre;
    int n, el;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valids", 64'({mem_req_valid_o, amo_valid_o, cpl_valid_o}), 64'd0);
    chk("rst_mem_fields", {mem_req_addr_o ^ mem_req_wdata_o}, 64'd0);
    chk("rst_cpl_fields", cpl_rd_o | 64'(cpl_tag_o) | 64'({cpl_fault_o, cpl_cause_o, mem_req_we_o}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    mem_mode = 0; cpl_mode = 0; lat = 1;
    mem[64'h1000] = 64'd5;
    run_txn(64'h1000, 64'd3, 5'h00, 6'd1, 1'b0, 1'b0, 7);
    chk("amoadd_mem", memrd(64'h1000), 64'd8);

    mem_mode = 2;
    mem[64'h1008] = '1;
    run_txn(64'h1008, 64'd1, 5'h1c, 6'd2, 1'b0, 1'b0, 0);
    chk("amomaxu_mem", memrd(64'h1008), '1);

    mem_mode = 0;
    run_txn(64'h1004, 64'd9, 5'h00, 6'd3, 1'b0, 1'b0, 1);
    run_txn(64'h1010, 64'd9, 5'h00, 6'd4, 1'b1, 1'b0, 3);
    run_txn(64'h1018, 64'd9, 5'h08, 6'd5, 1'b0, 1'b1, 7);
    rd_err = 1'b0; wr_err = 1'b0;
    cpl_mode = 2;
    run_txn(64'h1020, 64'h77, 5'h04, 6'd6, 1'b0, 1'b0, 7);
    cpl_mode = 0;

    // flush while the read is outstanding: the late response must be drained
    lat = 4;
    exp_rd.push_back(64'h3000);
    send(64'h3000, 64'd1, 5'h00, 6'd7);
    @(negedge clk);
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("drain_busy", 64'(busy_o), 64'd1);
    n = 0;
    while (!mem_resp_valid_i && n < 20) begin
      chk("drain_req_ready", 64'(req_ready_o), 64'd0);
      @(negedge clk); n++;
    end
    chk("drain_resp_seen", 64'(mem_resp_valid_i), 64'd1);
    @(negedge clk);
    chk("drain_done_ready", 64'(req_ready_o), 64'd1);
    repeat (4) @(negedge clk);
    chk("drain_rd_queue", 64'(exp_rd.size()), 64'd0);
    lat = 1;

    // flush coinciding with the write firing: write lands, no completion
    mem_mode = 2;
    mem[64'h3008] = 64'd10;
    exp_rd.push_back(64'h3008);
    exp_wr.push_back('{addr: 64'h3008, data: 64'd30});
    send(64'h3008, 64'd20, 5'h00, 6'd8);
    n = 0;
    do begin @(negedge clk); n++; end while (!(mem_req_valid_o && mem_req_we_o && mem_req_ready_i) && n < 100);
    chk("flushwr_fire_seen", 64'(mem_req_valid_o && mem_req_we_o && mem_req_ready_i), 64'd1);
    #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flushwr_wait_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    chk("flushwr_idle", 64'({busy_o, cpl_valid_o}), 64'd0);
    repeat (4) @(negedge clk);
    chk("flushwr_mem", memrd(64'h3008), 64'd30);
    chk("flushwr_queues", 64'(exp_wr.size() + exp_rd.size()), 64'd0);

    for (int i = 0; i < 16; i++) mem[64'h2000 + 64'(i) * 8] = {$urandom, $urandom};
    for (int i = 0; i < 40; i++) begin
      a = 64'h2000 + 64'($urandom_range(0, 15)) * 8;
      if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
      r = {$urandom, $urandom};
      rde = $urandom_range(0, 9) == 0;
      wre = !rde && ($urandom_range(0, 9) == 0);
      mem_mode = $urandom_range(0, 2);
      cpl_mode = $urandom_range(0, 2);
      lat = $urandom_range(1, 3);
      el = (mem_mode == 0 && lat == 1) ? ((a[2:0] != 3'd0) ? 1 : rde ? 3 : 7) : 0;
      run_txn(a, r, fl[$urandom_range(0, 8)], 6'(i), rde, wre, el);
    end

    repeat (5) @(negedge clk);
    chk("final_idle", 64'(busy_o), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
